// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a valid/ready FIFO. Each frame latches its own line
// configuration (length, parity, stop bits, baud divisor) when its word is popped.
module uart_tx_fifo #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                          Clock,
  input  logic                          ResetN,
  input  logic [7:0]                    DataIn,
  input  logic                          InValid,
  output logic                          InReady,
  input  logic                          Enable,
  input  logic [1:0]                    DataLength,
  input  logic [1:0]                    ParityType,
  input  logic                          StopBits,
  input  logic [DIV_WIDTH-1:0]          BaudDiv,
  output logic                          DataOut,
  output logic                          ActiveFlag,
  output logic                          DoneFlag,
  output logic [$clog2(FIFO_DEPTH):0]   FifoCount,
  output logic                          FifoEmpty,
  output logic                          FifoFull
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthCount = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // FIFO storage and status
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, ready_q;
  logic          push, pop;

  // Frame state
  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] timer_q, timer_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [1:0]           len_q, len_d;
  logic [1:0]           par_q, par_d;
  logic                 stop2_q, stop2_d;
  logic [7:0]           shreg_q, shreg_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 par_bit_q, par_bit_d;
  logic                 line_q, line_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;

  logic       bit_end, last_stop, has_parity, head_par;
  logic [7:0] head, head_mask;

  assign push = InValid & ~full_q;
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (push) mem_q[wr_ptr_q] <= DataIn;
  end

  // Status flags are registered from the next occupancy so they match FifoCount.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == DepthCount);
      empty_q <= (count_d == '0);
      ready_q <= (count_d != DepthCount);
    end
  end

  always_comb begin
    head_mask = 8'hFF;
    case (DataLength)
      2'b00:   head_mask = 8'h1F;
      2'b01:   head_mask = 8'h3F;
      2'b10:   head_mask = 8'h7F;
      default: head_mask = 8'hFF;
    endcase
  end

  assign head_par   = ^(head & head_mask);
  assign bit_end    = (timer_q == div_q);
  assign last_stop  = (state_q == StStop) && bit_end && (stop_idx_q == stop2_q);
  assign pop        = ~empty_q && Enable && ((state_q == StIdle) || last_stop);
  assign has_parity = (par_q == 2'b01) || (par_q == 2'b10);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    len_d      = len_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    par_bit_d  = par_bit_q;
    timer_d    = ((state_q == StIdle) || bit_end) ? '0 : timer_q + 1'b1;

    if (pop) begin
      state_d   = StStart;
      div_d     = BaudDiv;
      len_d     = DataLength;
      par_d     = ParityType;
      stop2_d   = StopBits;
      shreg_d   = head;
      par_bit_d = (ParityType == 2'b01) ? ~head_par : head_par;
    end else begin
      case (state_q)
        StIdle: state_d = StIdle;
        StStart: begin
          if (bit_end) begin
            state_d   = StData;
            bit_idx_d = '0;
          end
        end
        StData: begin
          if (bit_end) begin
            // Last data index is N-1 = DataLength + 4.
            if (bit_idx_q == {1'b1, len_q}) begin
              state_d    = has_parity ? StParity : StStop;
              stop_idx_d = 1'b0;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
              shreg_d   = shreg_q >> 1;
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            state_d    = StStop;
            stop_idx_d = 1'b0;
          end
        end
        StStop: begin
          if (bit_end) begin
            if (stop_idx_q == stop2_q) state_d = StIdle;
            else                       stop_idx_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    line_d = 1'b1;
    case (state_d)
      StStart:  line_d = 1'b0;
      StData:   line_d = shreg_d[0];
      StParity: line_d = par_bit_d;
      default:  line_d = 1'b1;
    endcase

    active_d = (state_d != StIdle);
    // Outputs are registered, so flag the cycle that will be the last stop clock.
    done_d   = (state_d == StStop) && (stop_idx_d == stop2_d) && (timer_d == div_d);
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      div_q      <= '0;
      len_q      <= '0;
      par_q      <= '0;
      stop2_q    <= 1'b0;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_bit_q  <= 1'b0;
      line_q     <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      div_q      <= div_d;
      len_q      <= len_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      par_bit_q  <= par_bit_d;
      line_q     <= line_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  assign DataOut    = line_q;
  assign ActiveFlag = active_q;
  assign DoneFlag   = done_q;
  assign FifoCount  = count_q;
  assign FifoEmpty  = empty_q;
  assign FifoFull   = full_q;
  assign InReady    = ready_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: expected line waveforms come from a
// bit-list frame model (start, data LSB first, parity, stops) expanded per clock.
module tb_uart_tx_fifo;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  data_in;
  logic        in_valid, in_ready, enable;
  logic [1:0]  data_length, parity_type;
  logic        stop_bits;
  logic [15:0] baud_div;
  logic        data_out, active_flag, done_flag;
  logic [4:0]  fifo_count;
  logic        fifo_empty, fifo_full;

  int errors = 0;
  int checks = 0;

  logic exp_line[$];
  logic exp_done[$];
  logic got_line[$];
  logic got_done[$];
  logic got_act[$];

  uart_tx_fifo #(.FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
    .Clock(clock), .ResetN(reset_n), .DataIn(data_in), .InValid(in_valid),
    .InReady(in_ready), .Enable(enable), .DataLength(data_length),
    .ParityType(parity_type), .StopBits(stop_bits), .BaudDiv(baud_div),
    .DataOut(data_out), .ActiveFlag(active_flag), .DoneFlag(done_flag),
    .FifoCount(fifo_count), .FifoEmpty(fifo_empty), .FifoFull(fifo_full)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Appends one frame's expected per-clock line level and done pulse.
  task automatic model_frame(input logic [7:0] d, input logic [1:0] len, input logic [1:0] par,
                             input logic stop, input int div);
    logic bits[$];
    logic p;
    int   n;
    n = int'(len) + 5;
    p = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(d[i]);
      p ^= d[i];
    end
    if (par == 2'b01) bits.push_back(~p);
    else if (par == 2'b10) bits.push_back(p);
    bits.push_back(1'b1);
    if (stop) bits.push_back(1'b1);
    foreach (bits[b]) begin
      for (int k = 0; k <= div; k++) begin
        exp_line.push_back(bits[b]);
        exp_done.push_back(1'b0);
      end
    end
    exp_done[exp_done.size()-1] = 1'b1;
  endtask

  task automatic set_cfg(input logic [1:0] len, input logic [1:0] par, input logic stop,
                         input logic [15:0] div);
    data_length = len;
    parity_type = par;
    stop_bits   = stop;
    baud_div    = div;
  endtask

  task automatic push_word(input logic [7:0] d);
    in_valid = 1'b1;
    data_in  = d;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    data_in  = 8'($urandom);
  endtask

  task automatic sample(input int n);
    got_line.delete();
    got_done.delete();
    got_act.delete();
    repeat (n) begin
      @(negedge clock);
      got_line.push_back(data_out);
      got_done.push_back(done_flag);
      got_act.push_back(active_flag);
    end
  endtask

  // Index of the first clock differing from the model, or -1.
  function automatic int frame_diff();
    if (got_line.size() != exp_line.size()) return 0;
    foreach (exp_line[i]) begin
      if (got_line[i] !== exp_line[i] || got_done[i] !== exp_done[i] || got_act[i] !== 1'b1)
        return i;
    end
    return -1;
  endfunction

  task automatic test_reset();
    logic [4:0] got[7];
    logic [4:0] want[7];
    string      names[7];
    reset_n  = 1'b0;
    in_valid = 1'b0;
    data_in  = 8'h00;
    enable   = 1'b1;
    set_cfg(2'b11, 2'b00, 1'b0, 16'd0);
    repeat (3) @(negedge clock);
    names[0] = "data_out";    got[0] = 5'(data_out);    want[0] = 5'd1;
    names[1] = "active_flag"; got[1] = 5'(active_flag); want[1] = 5'd0;
    names[2] = "done_flag";   got[2] = 5'(done_flag);   want[2] = 5'd0;
    names[3] = "fifo_count";  got[3] = fifo_count;      want[3] = 5'd0;
    names[4] = "fifo_empty";  got[4] = 5'(fifo_empty);  want[4] = 5'd1;
    names[5] = "fifo_full";   got[5] = 5'(fifo_full);   want[5] = 5'd0;
    names[6] = "in_ready";    got[6] = 5'(in_ready);    want[6] = 5'd1;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (got[i] !== want[i]) begin
        errors++;
        $display("FAIL reset %s: got %0d expected %0d", names[i], got[i], want[i]);
      end
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_single_frame(input string name, input logic [7:0] d, input logic [1:0] len,
                                   input logic [1:0] par, input logic stop, input int div);
    int bad;
    set_cfg(len, par, stop, 16'(div));
    exp_line.delete();
    exp_done.delete();
    model_frame(d, len, par, stop, div);
    push_word(d);
    @(negedge clock);
    checks++;
    if (data_out !== 1'b1 || active_flag !== 1'b0 || fifo_count !== 5'd1) begin
      errors++;
      $display("FAIL %s pre-pop: line=%b active=%b count=%0d, expected line=1 active=0 count=1",
               name, data_out, active_flag, fifo_count);
    end
    sample(exp_line.size());
    bad = frame_diff();
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s frame clock %0d: line=%b done=%b active=%b, expected line=%b done=%b active=1",
               name, bad, got_line[bad], got_done[bad], got_act[bad], exp_line[bad], exp_done[bad]);
    end
    @(negedge clock);
    checks++;
    if (data_out !== 1'b1 || active_flag !== 1'b0 || done_flag !== 1'b0 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL %s post-frame idle: line=%b active=%b done=%b empty=%b, expected 1 0 0 1",
               name, data_out, active_flag, done_flag, fifo_empty);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_spec_frames();
    enable = 1'b1;
    test_single_frame("8N1", 8'hA5, 2'b11, 2'b00, 1'b0, 3);
    test_single_frame("7E2", 8'h35, 2'b10, 2'b10, 1'b1, 0);
    test_single_frame("5O1", 8'hFF, 2'b00, 2'b01, 1'b0, 1);
  endtask

  task automatic test_random_frames();
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      test_single_frame("random", 8'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                        int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words[$];
    logic [1:0] len, par;
    logic       stop;
    int         div, bad;
    len  = 2'($urandom);
    par  = 2'($urandom);
    stop = 1'($urandom);
    div  = int'($urandom_range(0, 1));
    set_cfg(len, par, stop, 16'(div));
    enable   = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      data_in = 8'($urandom);
      @(posedge clock);
      if (words.size() < 16) words.push_back(data_in);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (fifo_count !== 5'd16) begin
      errors++;
      $display("FAIL fill fifo_count: got %0d expected 16", fifo_count);
    end
    checks++;
    if (fifo_full !== 1'b1) begin
      errors++;
      $display("FAIL fill fifo_full: got %b expected 1", fifo_full);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill in_ready: got %b expected 0", in_ready);
    end
    checks++;
    if (fifo_empty !== 1'b0 || data_out !== 1'b1) begin
      errors++;
      $display("FAIL fill idle: empty=%b line=%b expected empty=0 line=1", fifo_empty, data_out);
    end
    exp_line.delete();
    exp_done.delete();
    foreach (words[w]) model_frame(words[w], len, par, stop, div);
    enable = 1'b1;
    @(negedge clock);
    sample(exp_line.size());
    bad = frame_diff();
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL burst clock %0d: line=%b done=%b active=%b, expected line=%b done=%b active=1",
               bad, got_line[bad], got_done[bad], got_act[bad], exp_line[bad], exp_done[bad]);
    end
    @(negedge clock);
    checks++;
    if (active_flag !== 1'b0 || fifo_empty !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL burst end: active=%b empty=%b ready=%b expected 0 1 1",
               active_flag, fifo_empty, in_ready);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_cfg_change();
    logic [7:0] w1, w2;
    int         bad;
    w1 = 8'($urandom);
    w2 = 8'($urandom);
    enable = 1'b1;
    set_cfg(2'b11, 2'b00, 1'b0, 16'd3);
    exp_line.delete();
    exp_done.delete();
    model_frame(w1, 2'b11, 2'b00, 1'b0, 3);
    model_frame(w2, 2'b11, 2'b10, 1'b0, 7);
    push_word(w1);
    push_word(w2);
    checks++;
    if (fifo_count !== 5'd1) begin
      errors++;
      $display("FAIL push+pop same cycle fifo_count: got %0d expected 1", fifo_count);
    end
    baud_div    = 16'd7;
    parity_type = 2'b10;
    sample(exp_line.size());
    bad = frame_diff();
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL cfg change clock %0d: line=%b done=%b active=%b, expected line=%b done=%b active=1",
               bad, got_line[bad], got_done[bad], got_act[bad], exp_line[bad], exp_done[bad]);
    end
    @(negedge clock);
    checks++;
    if (active_flag !== 1'b0 || data_out !== 1'b1) begin
      errors++;
      $display("FAIL cfg change end: active=%b line=%b expected 0 1", active_flag, data_out);
    end
    parity_type = 2'b00;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset_mid();
    int bad_cycles;
    enable = 1'b1;
    set_cfg(2'b11, 2'b00, 1'b0, 16'd3);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      // First word has bit 0 low so the line is low during the first data bit.
      data_in = (i == 0) ? (8'($urandom) & 8'hFE) : 8'($urandom);
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (fifo_count !== 5'd3) begin
      errors++;
      $display("FAIL reset-mid queued: got fifo_count %0d expected 3", fifo_count);
    end
    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (active_flag !== 1'b1 || data_out !== 1'b0) begin
      errors++;
      $display("FAIL reset-mid data bit: active=%b line=%b expected 1 0", active_flag, data_out);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (data_out !== 1'b1) begin
      errors++;
      $display("FAIL reset-mid data_out: got %b expected 1", data_out);
    end
    checks++;
    if (fifo_count !== 5'd0 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL reset-mid fifo: count=%0d empty=%b expected 0 1", fifo_count, fifo_empty);
    end
    checks++;
    if (active_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset-mid active_flag: got %b expected 0", active_flag);
    end
    @(negedge clock);
    reset_n = 1'b1;
    bad_cycles = 0;
    repeat (30) begin
      @(negedge clock);
      if (data_out !== 1'b1 || active_flag !== 1'b0 || fifo_count !== 5'd0) bad_cycles++;
    end
    checks++;
    if (bad_cycles != 0) begin
      errors++;
      $display("FAIL reset-mid after release: %0d non-idle cycles, expected 0", bad_cycles);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    test_reset();
    test_spec_frames();
    test_random_frames();
    test_back_to_back();
    test_cfg_change();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
